// File: rtl/producer_pkg.sv
// Shared constants and FSM state type for the FIFO write-side producer.
// Params: WIDTH data bits, DEPTH (informational), PTR_WIDTH pointer bits.
package producer_pkg;
  localparam int WIDTH     = 1024;
  localparam int DEPTH     = 512;
  localparam int PTR_WIDTH = 9;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    GAP,
    DONE
  } state_e;
endpackage

// File: rtl/producer_if.sv
// FIFO write bus: Data_in/Write from producer, Full back from FIFO.
// master = producer side, slave = FIFO side.
interface producer_if;
  import producer_pkg::*;
  logic [WIDTH-1:0] Data_in;
  logic             Write;
  logic             Full;

  modport master (output Data_in, output Write, input Full);
  modport slave  (input Data_in, input Write, output Full);
endinterface

// File: rtl/producer_gap_timer.sv
// 8-bit loadable down-counter; expired_o while count is 0.
// Ports: clk, rst (sync high), load_i, value_i, expired_o.
module producer_gap_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] value_i,
  output logic       expired_o
);
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = value_i;
    else if (cnt_q != 8'd0)
      cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == 8'd0);
endmodule

// File: rtl/producer.sv
// Burst traffic source writing seed-derived words into an async FIFO.
// Ports: clk1, rst, fifo (master), Start/Burst_len/Num_bursts/
// Idle_cycles/Seed, Busy, Done, Sent_count; Stall_count if
// PRODUCER_STALL_CNT_EN is defined.
module producer
  import producer_pkg::*;
(
  input  logic               clk1,
  input  logic               rst,
  producer_if.master         fifo,
  input  logic               Start,
  input  logic [PTR_WIDTH:0] Burst_len,
  input  logic [3:0]         Num_bursts,
  input  logic [7:0]         Idle_cycles,
  input  logic [31:0]        Seed,
  output logic               Busy,
  output logic               Done,
  output logic [31:0]        Sent_count
`ifdef PRODUCER_STALL_CNT_EN
  ,
  output logic [31:0]        Stall_count
`endif
);
  localparam int REP = WIDTH / 32;
  typedef logic [PTR_WIDTH:0] len_t;

  function automatic logic [WIDTH-1:0] pattern(
    input logic [31:0] v
  );
    return {REP{v}};
  endfunction

  state_e           state_q, state_d;
  len_t             len_q, len_d;
  logic [3:0]       nb_q, nb_d;
  logic [7:0]       idle_q, idle_d;
  logic [31:0]      seed_q, seed_d;
  logic [31:0]      idx_q, idx_d;
  len_t             wcnt_q, wcnt_d;
  logic [3:0]       bcnt_q, bcnt_d;
  logic             wr_q, wr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [31:0]      sent_q, sent_d;

  logic       accept;
  logic       last_word;
  logic       last_burst;
  logic       gap_load;
  logic [7:0] gap_val;
  logic       gap_expired;

  assign accept     = wr_q & ~fifo.Full;
  assign last_word  = accept && (wcnt_q == len_q - len_t'(1));
  assign last_burst = (bcnt_q == nb_q - 4'd1);

  // Loaded with Idle_cycles-1 so GAP lasts exactly Idle_cycles.
  producer_gap_timer u_gap (
    .clk       (clk1),
    .rst       (rst),
    .load_i    (gap_load),
    .value_i   (gap_val),
    .expired_o (gap_expired)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    nb_d     = nb_q;
    idle_d   = idle_q;
    seed_d   = seed_q;
    bcnt_d   = bcnt_q;
    gap_load = 1'b0;
    gap_val  = idle_q - 8'd1;
    idx_d    = idx_q + 32'(accept);
    sent_d   = sent_q + 32'(accept);
    wcnt_d   = wcnt_q + len_t'(accept);

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          len_d  = Burst_len;
          nb_d   = Num_bursts;
          idle_d = Idle_cycles;
          seed_d = Seed;
          idx_d  = 32'd0;
          wcnt_d = '0;
          bcnt_d = 4'd0;
          if (Burst_len == '0 || Num_bursts == 4'd0)
            state_d = DONE;
          else
            state_d = BURST;
        end
      end
      BURST: begin
        if (last_word) begin
          wcnt_d = '0;
          if (last_burst) begin
            state_d = DONE;
          end else begin
            bcnt_d = bcnt_q + 4'd1;
            if (idle_q != 8'd0) begin
              state_d  = GAP;
              gap_load = 1'b1;
            end
          end
        end
      end
      GAP: begin
        if (gap_expired) state_d = BURST;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Stalled word keeps idx, so data re-derives to the same value.
    wr_d   = (state_d == BURST);
    data_d = wr_d ? pattern(seed_d + idx_d) : data_q;
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      nb_q    <= 4'd0;
      idle_q  <= 8'd0;
      seed_q  <= 32'd0;
      idx_q   <= 32'd0;
      wcnt_q  <= '0;
      bcnt_q  <= 4'd0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      sent_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      nb_q    <= nb_d;
      idle_q  <= idle_d;
      seed_q  <= seed_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      sent_q  <= sent_d;
    end
  end

`ifdef PRODUCER_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  assign stall_d = stall_q + 32'(wr_q & fifo.Full);
  always_ff @(posedge clk1) begin
    if (rst) stall_q <= 32'd0;
    else     stall_q <= stall_d;
  end
  assign Stall_count = stall_q;
`endif

  assign fifo.Write   = wr_q;
  assign fifo.Data_in = data_q;
  assign Busy         = (state_q != IDLE);
  assign Done         = (state_q == DONE);
  assign Sent_count   = sent_q;
endmodule

// File: tb/tb_producer.sv
// Directed bench for producer: per-cycle vector table plus
// hand sequences for Full stall and mid-burst reset.
module tb_producer;
  import producer_pkg::*;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        Start;
  logic [9:0]  Burst_len;
  logic [3:0]  Num_bursts;
  logic [7:0]  Idle_cycles;
  logic [31:0] Seed;
  logic        Busy, Done;
  logic [31:0] Sent_count;
`ifdef PRODUCER_STALL_CNT_EN
  logic [31:0] Stall_count;
`endif

  producer_if fifo ();

  producer dut (
    .clk1        (clk1),
    .rst         (rst),
    .fifo        (fifo.master),
    .Start       (Start),
    .Burst_len   (Burst_len),
    .Num_bursts  (Num_bursts),
    .Idle_cycles (Idle_cycles),
    .Seed        (Seed),
    .Busy        (Busy),
    .Done        (Done),
    .Sent_count  (Sent_count)
`ifdef PRODUCER_STALL_CNT_EN
    ,
    .Stall_count (Stall_count)
`endif
  );

  always #5 clk1 = ~clk1;

  typedef struct {
    logic        start;
    logic [9:0]  len;
    logic [3:0]  nb;
    logic [7:0]  idle;
    logic [31:0] seed;
    logic        full;
    logic        wr;
    logic [31:0] dat;
    logic        busy;
    logic        done;
    logic [31:0] sent;
  } vec_t;

  vec_t tbl[$];
  int   nchk  = 0;
  int   npass = 0;

  function automatic logic [WIDTH-1:0] rep(input logic [31:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic chkd(input string nm, input logic [WIDTH-1:0] act,
                      input logic [31:0] exp);
    nchk++;
    if (act === rep(exp)) npass++;
    else $display("FAIL %s: got low %h want %h replicated",
                  nm, act[31:0], exp);
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic add(input logic st, input logic [9:0] l,
                     input logic [3:0] n, input logic [7:0] g,
                     input logic [31:0] s, input logic f,
                     input logic w, input logic [31:0] d,
                     input logic b, input logic dn,
                     input logic [31:0] sc);
    vec_t v;
    v.start = st; v.len = l; v.nb = n; v.idle = g; v.seed = s;
    v.full = f; v.wr = w; v.dat = d; v.busy = b; v.done = dn;
    v.sent = sc;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; Start = 1'b0; Burst_len = '0; Num_bursts = '0;
    Idle_cycles = '0; Seed = '0; fifo.Full = 1'b0;
    step(); step();
    chk("rst_write", 32'(fifo.Write), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_sent", Sent_count, 0);
    chkd("rst_data", fifo.Data_in, 0);
    rst = 1'b0;
    step();

    // single burst of 4
    add(1, 4, 1, 0, 32'h10, 0, 1, 32'h10, 1, 0, 0);
    add(0, 4, 1, 0, 32'h10, 0, 1, 32'h11, 1, 0, 1);
    add(0, 4, 1, 0, 32'h10, 0, 1, 32'h12, 1, 0, 2);
    add(0, 4, 1, 0, 32'h10, 0, 1, 32'h13, 1, 0, 3);
    add(0, 4, 1, 0, 32'h10, 0, 0, 0,      1, 1, 4);
    add(0, 4, 1, 0, 32'h10, 0, 0, 0,      0, 0, 4);
    // 2 bursts of 3 with 2 idle
    add(1, 3, 2, 2, 32'h100, 0, 1, 32'h100, 1, 0, 4);
    add(0, 3, 2, 2, 32'h100, 0, 1, 32'h101, 1, 0, 5);
    add(0, 3, 2, 2, 32'h100, 0, 1, 32'h102, 1, 0, 6);
    add(0, 3, 2, 2, 32'h100, 0, 0, 0,       1, 0, 7);
    add(0, 3, 2, 2, 32'h100, 0, 0, 0,       1, 0, 7);
    add(0, 3, 2, 2, 32'h100, 0, 1, 32'h103, 1, 0, 7);
    add(0, 3, 2, 2, 32'h100, 0, 1, 32'h104, 1, 0, 8);
    add(0, 3, 2, 2, 32'h100, 0, 1, 32'h105, 1, 0, 9);
    add(0, 3, 2, 2, 32'h100, 0, 0, 0,       1, 1, 10);
    add(0, 3, 2, 2, 32'h100, 0, 0, 0,       0, 0, 10);
    // zero-length command
    add(1, 0, 1, 0, 32'h55, 0, 0, 0, 1, 1, 10);
    add(0, 0, 1, 0, 32'h55, 0, 0, 0, 0, 0, 10);
    // 3 back-to-back bursts of 2, Start mid-run ignored
    add(1, 2, 3, 0, 32'h200, 0, 1, 32'h200, 1, 0, 10);
    add(0, 2, 3, 0, 32'h200, 0, 1, 32'h201, 1, 0, 11);
    add(1, 5, 1, 0, 32'hF00, 0, 1, 32'h202, 1, 0, 12);
    add(0, 2, 3, 0, 32'h200, 0, 1, 32'h203, 1, 0, 13);
    add(0, 2, 3, 0, 32'h200, 0, 1, 32'h204, 1, 0, 14);
    add(0, 2, 3, 0, 32'h200, 0, 1, 32'h205, 1, 0, 15);
    add(0, 2, 3, 0, 32'h200, 0, 0, 0,       1, 1, 16);
    add(0, 2, 3, 0, 32'h200, 0, 0, 0,       0, 0, 16);

    for (int i = 0; i < tbl.size(); i++) begin
      Start = tbl[i].start; Burst_len = tbl[i].len;
      Num_bursts = tbl[i].nb; Idle_cycles = tbl[i].idle;
      Seed = tbl[i].seed; fifo.Full = tbl[i].full;
      step();
      Start = 1'b0;
      chk($sformatf("v%0d_write", i), 32'(fifo.Write), 32'(tbl[i].wr));
      chk($sformatf("v%0d_busy", i), 32'(Busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d_done", i), 32'(Done), 32'(tbl[i].done));
      chk($sformatf("v%0d_sent", i), Sent_count, tbl[i].sent);
      if (tbl[i].wr)
        chkd($sformatf("v%0d_data", i), fifo.Data_in, tbl[i].dat);
    end

    // burst of 8 with Full high for 5 cycles mid-burst
    begin
      int e, c;
      logic f;
      Start = 1'b1; Burst_len = 10'd8; Num_bursts = 4'd1;
      Idle_cycles = 8'd0; Seed = 32'h40;
      step();
      Start = 1'b0;
      e = 0; c = 1;
      while (e < 8 && c < 40) begin
        chk($sformatf("st%0d_write", c), 32'(fifo.Write), 1);
        chkd($sformatf("st%0d_data", c), fifo.Data_in, 32'h40 + e);
        chk($sformatf("st%0d_sent", c), Sent_count, 32'(16 + e));
        f = (c >= 3 && c <= 7);
        fifo.Full = f;
        step();
        if (!f) e++;
        c++;
      end
      fifo.Full = 1'b0;
      chk("st_words", 32'(e), 8);
      chk("st_cycles", 32'(c), 14);
      chk("st_done", 32'(Done), 1);
      chk("st_sent", Sent_count, 24);
`ifdef PRODUCER_STALL_CNT_EN
      chk("st_stall", Stall_count, 5);
`endif
      step();
      chk("st_idle", 32'(Busy), 0);
    end

    // reset during the 2nd word, then restart
    Start = 1'b1; Burst_len = 10'd4; Num_bursts = 4'd1; Seed = 32'h300;
    step();
    Start = 1'b0;
    chkd("rs_w0", fifo.Data_in, 32'h300);
    step();
    chkd("rs_w1", fifo.Data_in, 32'h301);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rs_write", 32'(fifo.Write), 0);
    chk("rs_busy", 32'(Busy), 0);
    chk("rs_done", 32'(Done), 0);
    chk("rs_sent", Sent_count, 0);
    Start = 1'b1;
    step();
    Start = 1'b0;
    chk("rs2_write", 32'(fifo.Write), 1);
    chkd("rs2_w0", fifo.Data_in, 32'h300);
    step();
    chkd("rs2_w1", fifo.Data_in, 32'h301);
    chk("rs2_sent", Sent_count, 1);
    repeat (4) step();
    chk("rs2_final_sent", Sent_count, 4);
    chk("rs2_final_busy", 32'(Busy), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
